// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer
// Data-memory stage behind the MIPS M stage. Stores are posted into a small
// circular write buffer and drained into a single-port word RAM on cycles
// without a load. Loads return data combinationally.
//
// Optional feature macro: DMEM_FWD_EN
//   defined   -> store-to-load forwarding from the youngest matching entry
//   undefined -> no forwarding mux; a load hitting a pending entry stalls
//                and the drain proceeds so the matching entry retires.
module dmem_write_buffer #(
    parameter int DEPTH     = 4,
    parameter int MEM_WORDS = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       MemWriteM,
    input  logic                       MemReadM,
    input  logic [31:0]                ALUOutM,
    input  logic [31:0]                WriteDataM,
    output logic [31:0]                ReadDataM,
    output logic                       MemStallM,
    output logic [$clog2(DEPTH+1)-1:0] wb_count,
    output logic                       wb_empty
);

    localparam int IW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Buffer entries: word index and data, addressed by head/tail pointers.
    logic [IW-1:0] entryIdx_q  [DEPTH];
    logic [31:0]   entryData_q [DEPTH];

    // Backing word RAM; contents survive reset.
    logic [31:0]   mem_q [MEM_WORDS];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, empty_d;

    logic [IW-1:0] wordIdx;
    logic          full;
    logic          matchHit;
    logic          enqEn;
    logic          drainEn;
    logic          unusedAddrBits;

`ifdef DMEM_FWD_EN
    logic [31:0]   fwdData;
`else
    logic          loadHit;
`endif

    assign wordIdx        = ALUOutM[IW+1:2];
    assign unusedAddrBits = ^{ALUOutM[31:IW+2], ALUOutM[1:0]};
    assign full           = (count_q == CW'(DEPTH));
    assign wb_count       = count_q;
    assign wb_empty       = empty_q;

    // Scan valid entries oldest to youngest so the last match wins.
    always_comb begin
        matchHit = 1'b0;
`ifdef DMEM_FWD_EN
        fwdData  = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) &&
                (entryIdx_q[head_q + PW'(i)] == wordIdx)) begin
                matchHit = 1'b1;
`ifdef DMEM_FWD_EN
                fwdData  = entryData_q[head_q + PW'(i)];
`endif
            end
        end
    end

    // Stall, drain and enqueue decisions plus the load data mux.
    always_comb begin
`ifdef DMEM_FWD_EN
        MemStallM = MemWriteM && full && MemReadM;
        drainEn   = !empty_q && !MemReadM;
        ReadDataM = matchHit ? fwdData : mem_q[wordIdx];
`else
        // A load hitting a pending store must wait; letting the drain run
        // during that stall is what eventually clears the hit.
        loadHit   = MemReadM && matchHit;
        MemStallM = (MemWriteM && full && MemReadM) || loadHit;
        drainEn   = !empty_q && (!MemReadM || (loadHit && !MemWriteM));
        ReadDataM = mem_q[wordIdx];
`endif
        enqEn = MemWriteM && !MemStallM;
    end

    // Next pointer and occupancy values.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (drainEn) begin
            head_d = head_q + PW'(1);
        end
        if (enqEn) begin
            tail_d = tail_q + PW'(1);
        end
        case ({enqEn, drainEn})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
    end

    // Pointer and occupancy registers; reset discards pending stores.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            empty_q <= empty_d;
        end
    end

    // Entry storage; only meaningful while counted as valid.
    always_ff @(posedge clk) begin
        if (enqEn) begin
            entryIdx_q[tail_q]  <= wordIdx;
            entryData_q[tail_q] <= WriteDataM;
        end
    end

    // Retire the head entry into RAM; a full-buffer enqueue may reuse the
    // same slot at this edge since the old value is read before the update.
    always_ff @(posedge clk) begin
        if (drainEn) begin
            mem_q[entryIdx_q[head_q]] <= entryData_q[head_q];
        end
    end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Testbench for dmem_write_buffer: directed scenarios plus randomized
// traffic, all checked against a queue-based reference model.
// Honours DMEM_FWD_EN the same way the design does.
module tb_dmem_write_buffer;

    localparam int DEPTH     = 4;
    localparam int MEM_WORDS = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM;
    logic        MemReadM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        MemStallM;
    logic [2:0]  wb_count;
    logic        wb_empty;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } entry_t;

    entry_t      pending [$];
    logic [31:0] ramModel [MEM_WORDS];
    bit          ramKnown [MEM_WORDS];
    int          vectorCount     = 0;
    int          miscompareCount = 0;
    logic [31:0] obsData;
    logic        obsStall;
    logic [31:0] vals [9];

    // Free-running clock.
    always #5 clk = ~clk;

    dmem_write_buffer #(
        .DEPTH(DEPTH),
        .MEM_WORDS(MEM_WORDS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .MemWriteM(MemWriteM),
        .MemReadM(MemReadM),
        .ALUOutM(ALUOutM),
        .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM),
        .MemStallM(MemStallM),
        .wb_count(wb_count),
        .wb_empty(wb_empty)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h",
                     tag, observed, expected);
        end
    endtask

    // One cycle of traffic: drive at negedge, check combinational outputs,
    // advance the model at posedge, then check the registered outputs.
    task automatic applyStimulus(input logic w, input logic r,
                                 input logic [31:0] addr, input logic [31:0] data);
        int          idx;
        bit          hit;
        bit          expStall;
        bit          drain;
        bit          doCheck;
        logic [31:0] youngest;
        logic [31:0] expData;
        idx      = int'(addr[7:2]);
        hit      = 1'b0;
        youngest = '0;
        @(negedge clk);
        MemWriteM  = w;
        MemReadM   = r;
        ALUOutM    = addr;
        WriteDataM = data;
        foreach (pending[k]) begin
            if (pending[k].idx == idx) begin
                hit      = 1'b1;
                youngest = pending[k].data;
            end
        end
`ifdef DMEM_FWD_EN
        expStall = w && r && (pending.size() == DEPTH);
        drain    = (pending.size() > 0) && !r;
        expData  = hit ? youngest : ramModel[idx];
        doCheck  = hit || ramKnown[idx];
`else
        expStall = (w && r && (pending.size() == DEPTH)) || (r && hit);
        drain    = (pending.size() > 0) && (!r || (hit && !w));
        expData  = ramModel[idx];
        doCheck  = ramKnown[idx];
`endif
        #1;
        obsData  = ReadDataM;
        obsStall = MemStallM;
        if (doCheck) checkOutput("ReadDataM", ReadDataM, expData);
        checkOutput("MemStallM", {31'd0, MemStallM}, {31'd0, expStall});
        @(posedge clk);
        if (drain) begin
            ramModel[pending[0].idx] = pending[0].data;
            ramKnown[pending[0].idx] = 1'b1;
            void'(pending.pop_front());
        end
        if (w && !expStall) pending.push_back('{idx, data});
        #1;
        checkOutput("wb_count", {29'd0, wb_count}, 32'(pending.size()));
        checkOutput("wb_empty", {31'd0, wb_empty}, {31'd0, pending.size() == 0});
    endtask

    initial begin
        logic [31:0] a;
        logic        rw;
        logic        rr;
        reset      = 1'b0;
        MemWriteM  = 1'b0;
        MemReadM   = 1'b0;
        ALUOutM    = '0;
        WriteDataM = '0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            ramKnown[i] = 1'b0;
            ramModel[i] = '0;
        end

        // Reset values
        #12;
        checkOutput("rstCount", {29'd0, wb_count}, 32'd0);
        checkOutput("rstEmpty", {31'd0, wb_empty}, 32'd1);
        checkOutput("rstStall", {31'd0, MemStallM}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Bring every RAM word to a known zero
        for (int i = 0; i < MEM_WORDS; i++) applyStimulus(1'b1, 1'b0, 32'(i << 2), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);

        // Reset with the buffer half full discards the pending stores
        applyStimulus(1'b1, 1'b1, 32'h0C, 32'h12345678);
        applyStimulus(1'b1, 1'b1, 32'h14, 32'h55AA55AA);
        checkOutput("halfFull", {29'd0, wb_count}, 32'd2);
        @(negedge clk);
        MemWriteM = 1'b0;
        MemReadM  = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("asyncRstCount", {29'd0, wb_count}, 32'd0);
        checkOutput("asyncRstEmpty", {31'd0, wb_empty}, 32'd1);
        pending.delete();
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h0C, 32'd0);
        checkOutput("ram3Kept", obsData, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h14, 32'd0);
        checkOutput("ram5Kept", obsData, 32'd0);

        // Store followed by a dependent load
        applyStimulus(1'b1, 1'b0, 32'h0C, 32'hDEADBEEF);
`ifdef DMEM_FWD_EN
        applyStimulus(1'b0, 1'b1, 32'h0C, 32'd0);
        checkOutput("fwdData", obsData, 32'hDEADBEEF);
        checkOutput("fwdNoStall", {31'd0, obsStall}, 32'd0);
`else
        applyStimulus(1'b0, 1'b1, 32'h0C, 32'd0);
        checkOutput("hitStall", {31'd0, obsStall}, 32'd1);
        applyStimulus(1'b0, 1'b1, 32'h0C, 32'd0);
        checkOutput("ramAfterStall", obsData, 32'hDEADBEEF);
        checkOutput("stallReleased", {31'd0, obsStall}, 32'd0);
`endif
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);

        // Two stores to one word: the last writer wins
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h11);
`ifdef DMEM_FWD_EN
        applyStimulus(1'b1, 1'b1, 32'h10, 32'h22);
        applyStimulus(1'b0, 1'b1, 32'h10, 32'd0);
        checkOutput("youngestFwd", obsData, 32'h22);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
`else
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h22);
`endif
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h10, 32'd0);
        checkOutput("ram4LastWriter", obsData, 32'h22);

        // Fill under continuous loads, then a store against a full buffer
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b1, 32'((10 + i) << 2), $urandom);
        checkOutput("filled", {29'd0, wb_count}, 32'd4);
        applyStimulus(1'b1, 1'b1, 32'(14 << 2), 32'hCAFE0001);
        checkOutput("fullStall", {31'd0, obsStall}, 32'd1);
        checkOutput("fullHeld", {29'd0, wb_count}, 32'd4);
        applyStimulus(1'b1, 1'b0, 32'(14 << 2), 32'hCAFE0002);
        checkOutput("fullAccept", {31'd0, obsStall}, 32'd0);
        checkOutput("fullSwap", {29'd0, wb_count}, 32'd4);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);

        // Nine back-to-back stores wrap the pointers twice
        for (int i = 0; i < 9; i++) begin
            vals[i] = $urandom;
            applyStimulus(1'b1, 1'b0, 32'((20 + i) << 2), vals[i]);
        end
        checkOutput("wrapCount", {29'd0, wb_count}, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("wrapEmpty", {31'd0, wb_empty}, 32'd1);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b1, 32'((20 + i) << 2), 32'd0);
            checkOutput("wrapRam", obsData, vals[i]);
        end

        // Randomized traffic over a few word indices to force matches
        for (int n = 0; n < 400; n++) begin
            a  = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2)
                 | 32'($urandom_range(0, 3));
            rw = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 2) == 0);
            applyStimulus(rw, rr, a, $urandom);
        end
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
